// File: rtl/car_game_pkg.sv
// Shared types and constants for the car game display path: frame sequencer
// states, colour width, native screen size and the scrolled-row helper.
package car_game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BG    = 3'd1,
        SPR   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int COLOUR_W = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Background row for screen row yc under a scroll offset, wrapped once into
    // 0..height-1 (yc and offset are each already below height).
    function automatic logic [7:0] wrap_row(input logic [6:0] yc,
                                            input logic [6:0] offset,
                                            input int         height);
        logic [7:0] sum;
        sum = {1'b0, yc} + {1'b0, offset};
        return (sum >= 8'(height)) ? (sum - 8'(height)) : sum;
    endfunction

endpackage

// File: rtl/frame_plot_sequencer_scroll_offset_ctr.sv
// Scroll offset for the background: collects ScrollStep ticks into a pending
// flag and steps the offset down one row (wrapping) when Apply is pulsed.
module scroll_offset_ctr
    import car_game_pkg::*;
#(
    parameter int HEIGHT = SCREEN_H
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       ScrollStep,
    input  logic       Apply,
    output logic [6:0] Offset
);

    logic [6:0] offset_q, offset_d;
    logic       pending_q, pending_d;

    always_comb begin
        offset_d  = offset_q;
        pending_d = pending_q;
        if (Apply) begin
            if (pending_q) begin
                offset_d = (offset_q == 7'd0) ? 7'(HEIGHT - 1) : (offset_q - 7'd1);
            end
            // A tick landing on the apply cycle belongs to the next frame.
            pending_d = ScrollStep;
        end else if (ScrollStep) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            offset_q  <= 7'd0;
            pending_q <= 1'b0;
        end else begin
            offset_q  <= offset_d;
            pending_q <= pending_d;
        end
    end

    assign Offset = offset_q;

endmodule

// File: rtl/frame_plot_sequencer.sv
// Draws one frame per Start: scrolled background, then the car sprite, through a
// single plot port. Optional sprite transparency: define SPRITE_TRANSPARENCY_EN.
module frame_plot_sequencer
    import car_game_pkg::*;
#(
    parameter int                     WIDTH       = SCREEN_W,
    parameter int                     HEIGHT      = SCREEN_H,
    parameter int                     SPR_W       = 8,
    parameter int                     SPR_H       = 12,
    parameter logic [COLOUR_W-1:0]    TRANSPARENT = 3'b000
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Start,
    input  logic                ScrollStep,
    input  logic [7:0]          CarX,
    input  logic [6:0]          CarY,
    output logic [14:0]         BgAddr,
    input  logic [COLOUR_W-1:0] BgColour,
    output logic [6:0]          SprAddr,
    input  logic [COLOUR_W-1:0] SprColour,
    output logic [7:0]          VGA_X,
    output logic [6:0]          VGA_Y,
    output logic [COLOUR_W-1:0] VGA_Colour,
    output logic                Plot,
    output logic                Busy,
    output logic                Done
);

    localparam logic [7:0] X_LAST  = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST  = 7'(HEIGHT - 1);
    localparam logic [6:0] SX_LAST = 7'(SPR_W - 1);
    localparam logic [6:0] SY_LAST = 7'(SPR_H - 1);

    state_t     state_q, state_d;
    logic [7:0] xc_q, xc_d;
    logic [6:0] yc_q, yc_d;
    logic [6:0] sx_q, sx_d;
    logic [6:0] sy_q, sy_d;
    logic [7:0] car_x_q, car_x_d;
    logic [6:0] car_y_q, car_y_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Pixel stage aligned with the 1-cycle ROM read latency.
    logic [7:0] pix_x_q, pix_x_d;
    logic [6:0] pix_y_q, pix_y_d;
    logic       pix_spr_q, pix_spr_d;
    logic       pix_v_q, pix_v_d;

    logic [6:0]  offset;
    logic        apply;
    logic [7:0]  bg_row;
    logic [14:0] bg_addr_w;
    logic [6:0]  spr_addr_w;
    logic [8:0]  spr_x;
    logic [7:0]  spr_y;
    logic        spr_in_bounds;
    logic        bg_last;
    logic        spr_last;

    scroll_offset_ctr #(
        .HEIGHT (HEIGHT)
    ) u_scroll (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .ScrollStep (ScrollStep),
        .Apply      (apply),
        .Offset     (offset)
    );

    assign apply = (state_q == DONE);

    // Address generation; offset is only stepped in DONE, so a frame never tears.
    always_comb begin
        bg_row     = wrap_row(yc_q, offset, HEIGHT);
        bg_addr_w  = 15'(bg_row) * 15'(WIDTH) + 15'(xc_q);
        spr_addr_w = sy_q * 7'(SPR_W) + sx_q;
        spr_x      = {1'b0, car_x_q} + 9'(sx_q);
        spr_y      = {1'b0, car_y_q} + 8'(sy_q);
        spr_in_bounds = (spr_x < 9'(WIDTH)) && (spr_y < 8'(HEIGHT));
        bg_last    = (xc_q == X_LAST) && (yc_q == Y_LAST);
        spr_last   = (sx_q == SX_LAST) && (sy_q == SY_LAST);
    end

    assign BgAddr  = (state_q == BG)  ? bg_addr_w  : 15'd0;
    assign SprAddr = (state_q == SPR) ? spr_addr_w : 7'd0;

    always_comb begin
        state_d   = state_q;
        xc_d      = xc_q;
        yc_d      = yc_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        car_x_d   = car_x_q;
        car_y_d   = car_y_q;
        pix_x_d   = 8'd0;
        pix_y_d   = 7'd0;
        pix_spr_d = 1'b0;
        pix_v_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    car_x_d = CarX;
                    car_y_d = CarY;
                    xc_d    = 8'd0;
                    yc_d    = 7'd0;
                    state_d = BG;
                end
            end
            BG: begin
                pix_x_d = xc_q;
                pix_y_d = yc_q;
                pix_v_d = 1'b1;
                if (xc_q == X_LAST) begin
                    xc_d = 8'd0;
                    yc_d = yc_q + 7'd1;
                end else begin
                    xc_d = xc_q + 8'd1;
                end
                if (bg_last) begin
                    xc_d    = 8'd0;
                    yc_d    = 7'd0;
                    sx_d    = 7'd0;
                    sy_d    = 7'd0;
                    state_d = SPR;
                end
            end
            SPR: begin
                // Off-screen sprite pixels still consume a cycle, only the strobe is dropped.
                pix_x_d   = spr_x[7:0];
                pix_y_d   = spr_y[6:0];
                pix_spr_d = 1'b1;
                pix_v_d   = spr_in_bounds;
                if (sx_q == SX_LAST) begin
                    sx_d = 7'd0;
                    sy_d = sy_q + 7'd1;
                end else begin
                    sx_d = sx_q + 7'd1;
                end
                if (spr_last) begin
                    sx_d    = 7'd0;
                    sy_d    = 7'd0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            xc_q      <= 8'd0;
            yc_q      <= 7'd0;
            sx_q      <= 7'd0;
            sy_q      <= 7'd0;
            car_x_q   <= 8'd0;
            car_y_q   <= 7'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pix_x_q   <= 8'd0;
            pix_y_q   <= 7'd0;
            pix_spr_q <= 1'b0;
            pix_v_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            xc_q      <= xc_d;
            yc_q      <= yc_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            car_x_q   <= car_x_d;
            car_y_q   <= car_y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            pix_spr_q <= pix_spr_d;
            pix_v_q   <= pix_v_d;
        end
    end

    // Plot stage: ROM data arrives now, one cycle after its address.
`ifdef SPRITE_TRANSPARENCY_EN
    assign Plot = pix_v_q && (!pix_spr_q || (SprColour != TRANSPARENT));
`else
    logic unused_transparent;
    assign unused_transparent = ^TRANSPARENT;
    assign Plot = pix_v_q;
`endif

    assign VGA_X      = pix_x_q;
    assign VGA_Y      = pix_y_q;
    assign VGA_Colour = !pix_v_q ? '0 : (pix_spr_q ? SprColour : BgColour);
    assign Busy       = busy_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_frame_plot_sequencer.sv
// Randomized bench for frame_plot_sequencer on a 4x3 screen with a 2x2 sprite,
// checked cycle by cycle against a frame-level model of the plot stream.
module tb_frame_plot_sequencer;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int SW    = 2;
    localparam int SH    = 2;
    localparam int FRAME = W * H + SW * SH + 2;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Start = 1'b0;
    logic        ScrollStep = 1'b0;
    logic [7:0]  CarX = 8'd0;
    logic [6:0]  CarY = 7'd0;
    logic [14:0] BgAddr;
    logic [2:0]  BgColour = 3'd0;
    logic [6:0]  SprAddr;
    logic [2:0]  SprColour = 3'd0;
    logic [7:0]  VGA_X;
    logic [6:0]  VGA_Y;
    logic [2:0]  VGA_Colour;
    logic        Plot;
    logic        Busy;
    logic        Done;

    logic [2:0] bg_rom  [W*H];
    logic [2:0] spr_rom [SW*SH];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference scroll state
    int m_offset = 0;
    bit m_pend   = 1'b0;

    frame_plot_sequencer #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .SPR_W       (SW),
        .SPR_H       (SH),
        .TRANSPARENT (3'b000)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
        .ScrollStep (ScrollStep),
        .CarX       (CarX),
        .CarY       (CarY),
        .BgAddr     (BgAddr),
        .BgColour   (BgColour),
        .SprAddr    (SprAddr),
        .SprColour  (SprColour),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .VGA_Colour (VGA_Colour),
        .Plot       (Plot),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 Clock = ~Clock;

    // Synchronous ROMs with one cycle of read latency
    always @(posedge Clock) begin
        BgColour  <= (int'(BgAddr) < W * H) ? bg_rom[int'(BgAddr)] : 3'd7;
        SprColour <= (int'(SprAddr) < SW * SH) ? spr_rom[int'(SprAddr)] : 3'd7;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bg_index(input int x, input int y);
        return ((y + m_offset) % H) * W + x;
    endfunction

    task automatic fill_roms(input bit spr_opaque);
        for (int i = 0; i < W * H; i++) bg_rom[i] = 3'($urandom_range(7, 0));
        for (int i = 0; i < SW * SH; i++)
            spr_rom[i] = spr_opaque ? 3'($urandom_range(7, 1)) : 3'($urandom_range(7, 0));
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_plot"}, 32'(Plot), 32'd0);
        check_eq({tag, "_busy"}, 32'(Busy), 32'd0);
        check_eq({tag, "_done"}, 32'(Done), 32'd0);
        check_eq({tag, "_bgaddr"}, 32'(BgAddr), 32'd0);
        check_eq({tag, "_spraddr"}, 32'(SprAddr), 32'd0);
        check_eq({tag, "_xyc"}, {14'd0, VGA_X, VGA_Y, VGA_Colour}, 32'd0);
    endtask

    // One frame: scroll_mask bit k drives ScrollStep during cycle k after the
    // accepting edge; start_k (1..FRAME) re-asserts Start while busy.
    task automatic run_frame(input int cx, input int cy, input logic [FRAME:0] scroll_mask,
                             input int start_k);
        bit         pend_now;
        bit         exp_plot;
        int         ex, ey, i, j;
        logic [2:0] ec;
        pend_now = m_pend || (|scroll_mask[FRAME-1:0]);

        @(posedge Clock); #1;
        Start      = 1'b1;
        CarX       = 8'(cx);
        CarY       = 7'(cy);
        ScrollStep = scroll_mask[0];
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(posedge Clock); #1;
            Start      = (k == start_k);
            CarX       = 8'($urandom);
            CarY       = 7'($urandom);
            ScrollStep = (k <= FRAME) ? scroll_mask[k] : 1'b0;
            @(negedge Clock);
            check_eq("busy", 32'(Busy), 32'(k <= FRAME));
            check_eq("done", 32'(Done), 32'(k == FRAME));
            if (k <= W * H)
                check_eq("bg_addr", 32'(BgAddr), 32'(bg_index((k - 1) % W, (k - 1) / W)));
            if (k > W * H && k <= W * H + SW * SH)
                check_eq("spr_addr", 32'(SprAddr), 32'(k - W * H - 1));

            exp_plot = 1'b0;
            ex = 0;
            ey = 0;
            ec = 3'd0;
            if (k >= 2 && k <= W * H + 1) begin
                i        = k - 2;
                ex       = i % W;
                ey       = i / W;
                ec       = bg_rom[bg_index(ex, ey)];
                exp_plot = 1'b1;
            end else if (k >= W * H + 2 && k <= W * H + SW * SH + 1) begin
                j        = k - W * H - 2;
                ex       = cx + j % SW;
                ey       = cy + j / SW;
                ec       = spr_rom[j];
                exp_plot = (ex < W) && (ey < H);
`ifdef SPRITE_TRANSPARENCY_EN
                if (ec == 3'b000) exp_plot = 1'b0;
`endif
            end
            check_eq("plot", 32'(Plot), 32'(exp_plot));
            if (exp_plot) begin
                check_eq("vga_x", 32'(VGA_X), 32'(ex));
                check_eq("vga_y", 32'(VGA_Y), 32'(ey));
                check_eq("vga_colour", 32'(VGA_Colour), 32'(ec));
            end
        end
        if (pend_now) m_offset = (m_offset == 0) ? H - 1 : m_offset - 1;
        m_pend = scroll_mask[FRAME];
    endtask

    task automatic reset_mid_frame(input int at_k);
        @(posedge Clock); #1;
        Start = 1'b1;
        CarX  = 8'd0;
        CarY  = 7'd0;
        for (int k = 1; k <= at_k; k++) begin
            @(posedge Clock); #1;
            Start = 1'b0;
        end
        @(negedge Clock);
        check_eq("midframe_plot", 32'(Plot), 32'd1);
        check_eq("midframe_busy", 32'(Busy), 32'd1);
        Resetn = 1'b0;
        @(posedge Clock); #1;
        Resetn = 1'b1;
        @(negedge Clock);
        check_quiet("after_reset");
        m_offset = 0;
        m_pend   = 1'b0;
    endtask

    initial begin
        fill_roms(1'b0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check_quiet("reset");
        @(posedge Clock); #1;
        Resetn = 1'b1;

        // Basic frame
        run_frame(1, 0, '0, 0);

        // One scroll tick, then two frames: second frame starts at row offset 2
        run_frame(0, 0, (FRAME + 1)'(1) << 5, 0);
        run_frame(0, 0, '0, 0);

        // Sprite at bottom-right corner, three of its pixels clipped
        fill_roms(1'b1);
        run_frame(3, 2, '0, 0);

        // Transparent colour at sprite address 1
        spr_rom[1] = 3'b000;
        run_frame(0, 0, '0, 0);

        // Start while busy plus three ticks in one frame -> one offset step
        run_frame(1, 1, ((FRAME + 1)'(1) << 2) | ((FRAME + 1)'(1) << 9) | ((FRAME + 1)'(1) << 15), 7);
        run_frame(1, 1, '0, 0);

        // Tick on the Done cycle belongs to the following frame
        run_frame(2, 1, (FRAME + 1)'(1) << FRAME, 0);
        run_frame(2, 1, '0, 0);
        run_frame(2, 1, '0, 0);

        // Random frames
        for (int n = 0; n < 8; n++) begin
            logic [FRAME:0] mask;
            mask = (FRAME + 1)'($urandom) & (FRAME + 1)'($urandom);
            fill_roms(1'b0);
            run_frame($urandom_range(5, 0), $urandom_range(4, 0), mask, $urandom_range(FRAME, 0));
        end

        // Make the offset nonzero, reset in the middle of the background, restart
        run_frame(0, 0, (FRAME + 1)'(1), 0);
        reset_mid_frame(5);
        run_frame(0, 0, '0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/frame_plot_sequencer.md
Name: frame_plot_sequencer

Overview:
- Sequences one complete frame redraw through the single vga_adapter write port (x, y, colour, plot).
- Phase 1: scrolled background from the background ROM. Phase 2: car sprite overlaid from the sprite ROM.
- Owns the scroll offset, the pixel counters and ROM addressing, and compensates for the 1-cycle ROM read latency.
- Sits between the game FSM, which issues Start and the car position, and the vga_adapter.

Parameters:
- WIDTH, 160, screen/background width in pixels.
- HEIGHT, 120, screen/background height in pixels.
- SPR_W, 8, sprite width.
- SPR_H, 12, sprite height.
- TRANSPARENT, 3'b000, sprite colour code treated as see-through.

Ports:
- Clock  in  1  system clock (CLOCK_50).
- Resetn  in  1  synchronous, active-low reset.
- Start  in  1  one-cycle request to draw one frame.
- ScrollStep  in  1  one-cycle tick; requests a one-row scroll at the next frame boundary.
- CarX  in  8  sprite left column; latched on an accepted Start.
- CarY  in  7  sprite top row; latched on an accepted Start.
- BgAddr  out  15  background ROM address.
- BgColour  in  3  background ROM data, valid 1 cycle after BgAddr.
- SprAddr  out  7  sprite ROM address (row*SPR_W+col).
- SprColour  in  3  sprite ROM data, valid 1 cycle after SprAddr.
- VGA_X  out  8  plot x.
- VGA_Y  out  7  plot y.
- VGA_Colour  out  3  plot colour.
- Plot  out  1  write strobe to vga_adapter.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (Resetn=0 at posedge, any state, including mid-frame):
  - state=IDLE; counters, Offset and pending-scroll flag = 0.
  - All outputs = 0. Plot drops the same edge; no partial pixel is emitted afterwards.
- State IDLE:
  - Start=1 -> latch CarX/CarY, clear XC/YC, go BG.
  - Start while not IDLE is ignored; it is not queued.
- State BG, one address per cycle:
  - XC runs 0..WIDTH-1. At XC=WIDTH-1, XC wraps to 0 and YC increments.
  - Row term: RY = YC+Offset, minus HEIGHT if >= HEIGHT.
  - BgAddr = RY*WIDTH+XC, computed 15 bits wide with no truncation.
  - After issuing XC=WIDTH-1, YC=HEIGHT-1: go SPR, clear counters.
- State SPR:
  - SX runs 0..SPR_W-1 and SY runs 0..SPR_H-1, row-major.
  - SprAddr = SY*SPR_W+SX.
  - After the last address: go DRAIN.
- State DRAIN: one cycle, so the final sprite pixel is plotted. Then go DONE.
- State DONE: Done=1 for one cycle, apply the pending scroll, go IDLE.
- Pipeline: one register stage holds {x, y, phase, valid} to match ROM latency.
  - Plot, VGA_X, VGA_Y and VGA_Colour appear exactly 1 cycle after the matching address.
  - The BG->SPR transition needs no bubble: the last BG pixel plots in the first SPR cycle.
- Sprite pixel output:
  - Position: VGA_X = CarX+SX, VGA_Y = CarY+SY, with 9-bit/8-bit intermediates.
  - Clipping: if x >= WIDTH or y >= HEIGHT, Plot=0 for that pixel. Counters still advance.
- Frame length: WIDTH*HEIGHT + SPR_W*SPR_H + 2 cycles from the first BG address to Done. Busy covers exactly these cycles.
- Scroll:
  - ScrollStep sets the pending flag in any state; multiple ticks within one frame collapse to one step.
  - At DONE with pending=1: Offset = (Offset==0) ? HEIGHT-1 : Offset-1, and the flag clears. The road moves downward.
  - ScrollStep in the same cycle as DONE counts toward the next frame.
- Offset never changes mid-frame, so there is no tearing.

Optional Feature:
- Macro: SPRITE_TRANSPARENCY_EN.
- Defined: a sprite pixel with SprColour==TRANSPARENT gives Plot=0, and the background shows through.
- Undefined: every in-bounds sprite pixel is plotted, including TRANSPARENT; the comparator is removed.
- Clipping and timing are identical in both builds.

Decomposition:
- Shared package (car_game_pkg):
  - state enum {IDLE, BG, SPR, DRAIN, DONE}.
  - colour width constant COLOUR_W=3.
  - screen constants SCREEN_W=160, SCREEN_H=120.
- Sub-module scroll_offset_ctr:
  - Owns Offset, the pending flag and the wrap decrement.
  - Ports: Clock, Resetn, ScrollStep, Apply, Offset.
- Counters, address generation and the pipeline stage stay in the top module.

Test Plan:
- Bench settings for all cases: WIDTH=4, HEIGHT=3, SPR_W=2, SPR_H=2, Offset=0, transparency enabled.
1. Basic frame: Start -> BgAddr sequence 0..11, one per cycle. Plot high from cycle 1; first plot (0,0) carries BgColour of addr 0. Done exactly 18 cycles after Start is accepted, Busy high across those cycles.
2. Scroll: one ScrollStep, then two frames -> the second frame's first BgAddr is 8 (Offset=2). Row YC=1 reads address 0..3; wrap is correct.
3. Sprite placement: CarX=3, CarY=2, all sprite colours non-transparent -> pixel (3,2) is plotted; (4,2), (3,3) and (4,3) have Plot=0 (clipped). SprAddr still steps 0..3.
4. Transparency: SprColour=000 at SprAddr 1 -> no plot for that pixel. With the macro undefined, colour 000 is plotted.
5. Reset mid-BG at cycle 5: Plot=0 on the next edge, Busy=0, Offset=0. A new Start restarts from BgAddr 0.
6. Start during Busy and three ScrollSteps in one frame -> second Start ignored, Done once, Offset moves by exactly one row.
